// File: rtl/ser_rx.sv
// Serial frame receiver: start bit, DW data bits LSB first, optional even parity, stop bit.
// One bit per clock, no oversampling; result pulses one cycle after the stop-bit edge.
module ser_rx #(
    parameter int DW     = 8,
    parameter int PAR_EN = 1
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          D,
    output logic [DW-1:0] Q,
    output logic          VALID,
    output logic          ERR,
    output logic          BUSY,
    output logic [7:0]    CNT
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [DW-1:0]   shift_reg;
    logic [DW-1:0]   shift_next;
    logic [CW-1:0]   bit_cnt_reg;
    logic            par_err_reg;
    logic            ok_pend_reg;
    logic            err_pend_reg;

    // LSB-first: each new bit enters at the top and works its way down.
    generate
        if (DW == 1) begin : g_shift_one
            assign shift_next = D;
        end else begin : g_shift_many
            assign shift_next = {D, shift_reg[DW-1:1]};
        end
    endgenerate

    always_ff @(posedge CK) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!D) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_cnt_reg == LAST_BIT) begin
                    state_next = (PAR_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY:  state_next = STOP;
            STOP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The stop-bit verdict is held for one edge in *_pend_reg so that the
    // result pulses land one edge later, while the FSM is already free to
    // accept a back-to-back start bit.
    always_ff @(posedge CK) begin
        if (RST) begin
            Q            <= '0;
            VALID        <= 1'b0;
            ERR          <= 1'b0;
            BUSY         <= 1'b0;
            CNT          <= 8'd0;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            par_err_reg  <= 1'b0;
            ok_pend_reg  <= 1'b0;
            err_pend_reg <= 1'b0;
        end else begin
            VALID        <= ok_pend_reg;
            ERR          <= err_pend_reg;
            ok_pend_reg  <= 1'b0;
            err_pend_reg <= 1'b0;
            BUSY         <= (state_next != IDLE);
            if (ok_pend_reg) begin
                Q   <= shift_reg;
                CNT <= CNT + 8'd1;
            end
            case (state_reg)
                IDLE: begin
                    bit_cnt_reg <= '0;
                    par_err_reg <= 1'b0;
                end
                DATA: begin
                    shift_reg   <= shift_next;
                    bit_cnt_reg <= bit_cnt_reg + CW'(1);
                end
                PARITY: begin
                    par_err_reg <= (^shift_reg) ^ D;
                end
                STOP: begin
                    if (D && !par_err_reg) begin
                        ok_pend_reg <= 1'b1;
                    end else begin
                        err_pend_reg <= 1'b1;
                    end
                end
                default: begin
                    bit_cnt_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser_rx.sv
// Directed and randomized frames for ser_rx, checked against a frame-level model
// that predicts the edge, kind, word and count of every VALID/ERR pulse.
module tb_ser_rx;

    logic       CK = 1'b0;
    logic       RST = 1'b1;
    logic       D = 1'b1;
    logic       D1 = 1'b1;
    logic [7:0] Q, Q1, CNT, CNT1;
    logic       VALID, ERR, BUSY, VALID1, ERR1, BUSY1;

    ser_rx #(.DW(8), .PAR_EN(1)) u0 (
        .CK(CK), .RST(RST), .D(D), .Q(Q), .VALID(VALID),
        .ERR(ERR), .BUSY(BUSY), .CNT(CNT)
    );

    ser_rx #(.DW(8), .PAR_EN(0)) u1 (
        .CK(CK), .RST(RST), .D(D1), .Q(Q1), .VALID(VALID1),
        .ERR(ERR1), .BUSY(BUSY1), .CNT(CNT1)
    );

    always #5 CK = ~CK;

    typedef struct {
        int         cyc;
        logic       v;
        logic       e;
        logic [7:0] q;
        logic [7:0] cnt;
    } ev_t;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  exp_q[2][$];
    ev_t  mon_q[2][$];
    logic [7:0] model_cnt[2];
    logic [7:0] model_q[2];

    always @(posedge CK) cyc <= cyc + 1;

    // Record every pulse with the edge number it followed.
    always @(posedge CK) begin
        #1;
        if (VALID || ERR)   mon_q[0].push_back('{cyc, VALID, ERR, Q, CNT});
        if (VALID1 || ERR1) mon_q[1].push_back('{cyc, VALID1, ERR1, Q1, CNT1});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int w, input logic b);
        if (w == 0) D = b; else D1 = b;
        @(negedge CK);
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            model_cnt[w] = 8'd0;
            model_q[w]   = 8'd0;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        D   = 1'b1;
        D1  = 1'b1;
        @(negedge CK);
        RST = 1'b0;
        model_reset();
    endtask

    task automatic send_frame(input int w, input logic [7:0] data,
                              input logic bad_par, input logic stop_bit);
        int   par_en;
        int   start;
        logic good;
        par_en = (w == 0) ? 1 : 0;
        start  = cyc + 1;
        drive(w, 1'b0);
        if (w == 0) chk("busy_after_start", BUSY, 1'b1);
        for (int i = 0; i < 8; i++) drive(w, data[i]);
        if (par_en != 0) drive(w, (^data) ^ bad_par);
        drive(w, stop_bit);
        good = stop_bit && !(par_en != 0 && bad_par);
        if (good) begin
            model_cnt[w] = model_cnt[w] + 8'd1;
            model_q[w]   = data;
        end
        exp_q[w].push_back('{start + 2 + 8 + par_en, good, !good, model_q[w], model_cnt[w]});
    endtask

    task automatic check_events();
        ev_t e;
        ev_t m;
        D  = 1'b1;
        D1 = 1'b1;
        repeat (4) @(negedge CK);
        for (int w = 0; w < 2; w++) begin
            while (exp_q[w].size() > 0) begin
                e = exp_q[w].pop_front();
                chk($sformatf("u%0d_pulse_present@%0d", w, e.cyc), mon_q[w].size() > 0, 1'b1);
                if (mon_q[w].size() > 0) begin
                    m = mon_q[w].pop_front();
                    chk($sformatf("u%0d_pulse_edge", w), m.cyc, e.cyc);
                    chk($sformatf("u%0d_valid@%0d", w, e.cyc), m.v, e.v);
                    chk($sformatf("u%0d_err@%0d", w, e.cyc), m.e, e.e);
                    chk($sformatf("u%0d_q@%0d", w, e.cyc), m.q, e.q);
                    chk($sformatf("u%0d_cnt@%0d", w, e.cyc), m.cnt, e.cnt);
                end
            end
            chk($sformatf("u%0d_extra_pulses", w), mon_q[w].size(), 0);
            mon_q[w].delete();
        end
        chk("busy_idle", BUSY, 1'b0);
        chk("q_hold", Q, model_q[0]);
        chk("cnt_hold", CNT, model_cnt[0]);
    endtask

    initial begin
        logic [7:0] data;
        int         kind;
        model_reset();
        repeat (2) @(negedge CK);
        chk("rst_q", Q, 8'h00);
        chk("rst_valid", VALID, 1'b0);
        chk("rst_err", ERR, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_cnt", CNT, 8'h00);
        RST = 1'b0;

        // Good 0xA5 starting on the very first edge after reset release.
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        check_events();

        // Parity error on the same word.
        send_frame(0, 8'hA5, 1'b1, 1'b1);
        check_events();

        // Framing error, then a good copy of the same word.
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 1'b1);
        check_events();

        // Back-to-back frames with no idle bit.
        send_frame(0, 8'h01, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b1);
        check_events();

        // Abort after four data bits, then a good frame.
        drive(0, 1'b0);
        for (int i = 0; i < 4; i++) drive(0, i[0]);
        RST = 1'b1;
        D   = 1'b0;
        @(negedge CK);
        RST = 1'b0;
        model_reset();
        send_frame(0, 8'h55, 1'b0, 1'b1);
        check_events();

        // Random mix of good, parity-error and stop-error frames with random gaps.
        for (int n = 0; n < 40; n++) begin
            data = 8'($urandom);
            kind = $urandom_range(0, 3);
            send_frame(0, data, kind == 0, kind != 1);
            repeat ($urandom_range(0, 2)) drive(0, 1'b1);
        end
        check_events();

        // 256 good frames wrap the counter back to zero.
        do_reset();
        for (int n = 0; n < 256; n++) send_frame(0, 8'($urandom), 1'b0, 1'b1);
        check_events();
        chk("cnt_wrap", CNT, 8'h00);

        // No-parity instance: shorter frame, good then framing error.
        send_frame(1, 8'h80, 1'b0, 1'b1);
        send_frame(1, 8'h03, 1'b0, 1'b0);
        check_events();
        chk("nopar_q", Q1, 8'h80);
        chk("nopar_cnt", CNT1, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
